// File: rtl/cfi_violation_queue_pkg.sv
// Shared types and defaults for the CFI violation queue.
// Widths mirror an RV64 core with Sv39 virtual addresses.
package cfi_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned VLEN = 39;

   localparam int unsigned CFI_DEPTH_DEFAULT = 4;
   localparam int unsigned CFI_CNT_W_DEFAULT = 16;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
   } cfi_entry_t;

   function automatic logic [XLEN-1:0] pc_to_tval(input logic [VLEN-1:0] pc);
      return {{(XLEN-VLEN){1'b0}}, pc};
   endfunction

endpackage

// File: rtl/cfi_violation_queue_if.sv
// Parser-to-commit exception channel seen by the CFI violation queue.
// master = parser/commit side, slave = the queue.
interface cfi_violation_queue_if;

   cfi_pkg::exception_t             violation_i;
   logic [cfi_pkg::VLEN-1:0]        violation_pc_i;
   logic                            ex_ack_i;
   cfi_pkg::exception_t             exception_o;

   modport master (
      output violation_i,
      output violation_pc_i,
      output ex_ack_i,
      input  exception_o
   );

   modport slave (
      input  violation_i,
      input  violation_pc_i,
      input  ex_ack_i,
      output exception_o
   );

endinterface

// File: rtl/cfi_viol_fifo.sv
// Small power-of-two FIFO holding queued CFI violations.
// Flush empties it; a push while full is accepted only alongside a pop.
module cfi_viol_fifo
   import cfi_pkg::*;
#(
   parameter int unsigned DEPTH = CFI_DEPTH_DEFAULT,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic       push_i,
   input  cfi_entry_t data_i,
   input  logic       pop_i,
   output cfi_entry_t head_o,
   output logic [AW:0] count_o,
   output logic       full_o,
   output logic       empty_o
);

   cfi_entry_t     r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   assign full_o    = (r_count == (AW+1)'(DEPTH));
   assign empty_o   = (r_count == '0);
   assign w_do_pop  = pop_i && !empty_o;
   assign w_do_push = push_i && (!full_o || w_do_pop);
   assign head_o    = r_mem[r_rptr];
   assign count_o   = r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_do_pop) r_rptr <= r_rptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/cfi_violation_queue.sv
// Queues CFI violation pulses and presents them one at a time to commit/CSR.
// Optional saturating violation counter: define CFI_VIOLATION_COUNTER_EN (CNT_W >= 4).
module cfi_violation_queue
   import cfi_pkg::*;
#(
   parameter int unsigned DEPTH = CFI_DEPTH_DEFAULT,
   parameter int unsigned CNT_W = CFI_CNT_W_DEFAULT,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  csr_en_i,
   cfi_violation_queue_if.slave  viol_if,
   output logic                  pending_o,
   output logic                  overflow_o,
   output logic [CNT_W-1:0]      viol_count_o,
   output logic [7:0]            leds
);

   cfi_entry_t  w_entry;
   cfi_entry_t  w_head;
   logic [AW:0] w_count;
   logic [AW:0] w_count_nxt;
   logic        w_full;
   logic        w_empty;
   logic        w_viol;
   logic        w_push_req;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;
   logic [3:0]  w_led_cnt;
   logic        r_overflow;
   logic [7:0]  r_leds;

   assign w_viol     = viol_if.violation_i.valid && csr_en_i;
   assign w_push_req = w_viol && !flush_i;
   assign w_pop      = !w_empty && viol_if.ex_ack_i && !flush_i;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   assign w_entry.cause = viol_if.violation_i.cause;
   assign w_entry.tval  = pc_to_tval(viol_if.violation_pc_i);

   cfi_viol_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  (w_entry),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Mirrors the FIFO's next occupancy so the pending LED lines up with pending_o.
   always_comb begin
      w_count_nxt = w_count;
      if (flush_i)                w_count_nxt = '0;
      else if (w_push && !w_pop)  w_count_nxt = w_count + 1'b1;
      else if (!w_push && w_pop)  w_count_nxt = w_count - 1'b1;
   end

   assign pending_o                 = !w_empty;
   assign viol_if.exception_o.valid = !w_empty;
   assign viol_if.exception_o.cause = w_empty ? '0 : w_head.cause;
   assign viol_if.exception_o.tval  = w_empty ? '0 : w_head.tval;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
   end
   assign overflow_o = r_overflow;

`ifdef CFI_VIOLATION_COUNTER_EN
   logic [CNT_W-1:0] r_viol_count;
   logic [CNT_W-1:0] w_viol_count_nxt;

   // Counts every enabled violation, including dropped and flushed ones.
   assign w_viol_count_nxt = (w_viol && (r_viol_count != '1)) ? r_viol_count + 1'b1
                                                               : r_viol_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_viol_count <= '0;
      else         r_viol_count <= w_viol_count_nxt;
   end

   assign viol_count_o = r_viol_count;
   assign w_led_cnt    = w_viol_count_nxt[3:0];
`else
   assign viol_count_o = '0;
   assign w_led_cnt    = 4'h0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_leds <= '0;
      end else begin
         r_leds <= {r_leds[7] ^ w_push, csr_en_i, (w_count_nxt != '0),
                    r_overflow | w_drop, w_led_cnt};
      end
   end
   assign leds = r_leds;

endmodule

// File: tb/tb_cfi_violation_queue.sv
// Directed self-checking bench for cfi_violation_queue (DEPTH=4, CNT_W=4).
// Counter expectations follow CFI_VIOLATION_COUNTER_EN.
module tb_cfi_violation_queue;
   import cfi_pkg::*;

`ifdef CFI_VIOLATION_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       flush_i = 1'b0;
   logic       csr_en_i = 1'b0;
   logic       pending_o;
   logic       overflow_o;
   logic [3:0] viol_count_o;
   logic [7:0] leds;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;

   cfi_violation_queue_if vif ();

   cfi_violation_queue #(.DEPTH(4), .CNT_W(4)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .csr_en_i     (csr_en_i),
      .viol_if      (vif),
      .pending_o    (pending_o),
      .overflow_o   (overflow_o),
      .viol_count_o (viol_count_o),
      .leds         (leds)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] cause, input logic [VLEN-1:0] pc);
      vif.violation_i.valid = v;
      vif.violation_i.cause = cause;
      vif.violation_i.tval  = '0;
      vif.violation_pc_i    = pc;
   endtask

   // Saturating model of the counter, zero when the counter is not built.
   task automatic count_viol();
      if (CNT_EN && exp_cnt < 15) exp_cnt++;
   endtask

   task automatic chk_head(input string tag, input logic v, input logic [63:0] cause,
                           input logic [63:0] tval);
      chk({tag, "_valid"}, vif.exception_o.valid, v);
      chk({tag, "_cause"}, vif.exception_o.cause, cause);
      chk({tag, "_tval"},  vif.exception_o.tval, tval);
      chk({tag, "_pend"},  pending_o, v);
   endtask

   initial begin
      drive(1'b0, 64'd0, '0);
      vif.ex_ack_i = 1'b0;

      // Reset state
      #3;
      chk_head("rst", 1'b0, 64'd0, 64'd0);
      chk("rst_ovf", overflow_o, 1'b0);
      chk("rst_cnt", viol_count_o, 4'd0);
      chk("rst_leds", leds, 8'h00);
      #14 rst_ni = 1'b1;
      csr_en_i = 1'b1;
      tick();

      // Single violation held until acknowledged
      drive(1'b1, 64'd3, 39'h80000104);
      tick(); count_viol();
      drive(1'b0, 64'd0, '0);
      chk_head("t1", 1'b1, 64'd3, 64'h80000104);
      chk("t1_leds", leds, CNT_EN ? 8'hE1 : 8'hE0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_head("t1_hold", 1'b1, 64'd3, 64'h80000104);
      end
      vif.ex_ack_i = 1'b1;
      tick();
      vif.ex_ack_i = 1'b0;
      chk_head("t1_ack", 1'b0, 64'd0, 64'd0);
      chk("t1_cnt", viol_count_o, 4'(exp_cnt));
      chk("t1_leds_ack", leds, CNT_EN ? 8'hC1 : 8'hC0);

      // Burst of four, then a dropped fifth, then drain
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'd3, 39'(32'h100 + 4 * i));
         tick(); count_viol();
      end
      drive(1'b1, 64'd3, 39'h110);
      tick(); count_viol();
      drive(1'b0, 64'd0, '0);
      chk("t2_ovf", overflow_o, 1'b1);
      chk("t2_cnt", viol_count_o, 4'(exp_cnt));
      chk_head("t2_h0", 1'b1, 64'd3, 64'h100);
      vif.ex_ack_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk_head("t2_drain", 1'b1, 64'd3, 64'(32'h100 + 4 * i));
      end
      tick();
      vif.ex_ack_i = 1'b0;
      chk_head("t2_empty", 1'b0, 64'd0, 64'd0);

      // Full queue with simultaneous push and pop keeps occupancy at four
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 64'd2, 39'(32'h300 + 4 * i));
         tick(); count_viol();
      end
      vif.ex_ack_i = 1'b1;
      drive(1'b1, 64'd5, 39'h200);
      tick(); count_viol();
      vif.ex_ack_i = 1'b0;
      drive(1'b1, 64'd5, 39'h210);
      tick(); count_viol();
      drive(1'b0, 64'd0, '0);
      chk_head("t3_held", 1'b1, 64'd2, 64'h304);
      vif.ex_ack_i = 1'b1;
      tick(); chk_head("t3_d1", 1'b1, 64'd2, 64'h308);
      tick(); chk_head("t3_d2", 1'b1, 64'd2, 64'h30C);
      tick(); chk_head("t3_d3", 1'b1, 64'd5, 64'h200);
      tick(); chk_head("t3_d4", 1'b0, 64'd0, 64'd0);
      vif.ex_ack_i = 1'b0;
      chk("t3_cnt", viol_count_o, 4'(exp_cnt));

      // Flush beats a simultaneous push and ack
      drive(1'b1, 64'd3, 39'h400); tick(); count_viol();
      drive(1'b1, 64'd3, 39'h404); tick(); count_viol();
      chk_head("t4_pre", 1'b1, 64'd3, 64'h400);
      flush_i = 1'b1;
      vif.ex_ack_i = 1'b1;
      drive(1'b1, 64'd3, 39'h408);
      tick(); count_viol();
      flush_i = 1'b0;
      vif.ex_ack_i = 1'b0;
      drive(1'b0, 64'd0, '0);
      chk_head("t4_flush", 1'b0, 64'd0, 64'd0);
      tick();
      chk_head("t4_after", 1'b0, 64'd0, 64'd0);
      chk("t4_ovf", overflow_o, 1'b1);
      chk("t4_cnt", viol_count_o, 4'(exp_cnt));

      // Enforcement disabled: pulses ignored
      csr_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'd3, 39'(32'h500 + 4 * i));
         tick();
      end
      drive(1'b0, 64'd0, '0);
      chk_head("t5", 1'b0, 64'd0, 64'd0);
      chk("t5_cnt", viol_count_o, 4'(exp_cnt));
      chk("t5_led_en", leds[6], 1'b0);

      // Fresh reset, saturating burst, then asynchronous reset mid-burst
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      exp_cnt = 0;
      csr_en_i = 1'b1;
      chk("t6_cnt0", viol_count_o, 4'd0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 64'd3, 39'(32'h600 + 4 * i));
         tick(); count_viol();
      end
      chk("t6_sat", viol_count_o, CNT_EN ? 4'd15 : 4'd0);
      chk("t6_ovf", overflow_o, 1'b1);
      chk_head("t6_head", 1'b1, 64'd3, 64'h600);
      #3;
      rst_ni = 1'b0;
      #1;
      chk_head("t6_rst", 1'b0, 64'd0, 64'd0);
      chk("t6_rst_ovf", overflow_o, 1'b0);
      chk("t6_rst_cnt", viol_count_o, 4'd0);
      chk("t6_rst_leds", leds, 8'h00);
      drive(1'b0, 64'd0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cfi_violation_queue.md
# cfi_violation_queue

Buffers the one-cycle control-flow-integrity violation pulses produced by the commit-side call/ret NOP parser and presents them, one at a time and held until acknowledged, to the commit/CSR exception path. Sits directly downstream of the parser, between its `exception_o` and the commit stage's exception input. Also keeps a saturating violation counter and a sticky overflow flag, and drives the board debug LEDs.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the violation counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: pipeline flush; empties the queue.
- `csr_en_i`, in, 1: CFI enforcement enable. When low, incoming violations are ignored.
- `violation_i`, in, `ariane_pkg::exception_t`: parser output; `valid` is a single-cycle pulse.
- `violation_pc_i`, in, `riscv::VLEN`: PC of the offending commit, valid with `violation_i.valid`.
- `ex_ack_i`, in, 1: commit/CSR has taken the presented exception.
- `exception_o`, out, `ariane_pkg::exception_t`: head of the queue.
- `pending_o`, out, 1: queue not empty.
- `overflow_o`, out, 1: sticky; a violation was dropped because the queue was full.
- `viol_count_o`, out, `CNT_W`: saturating violation count.
- `leds`, out, 8: debug LEDs.

## Operation
- Push condition: `violation_i.valid && csr_en_i && !flush_i`. The entry stored is {cause = `violation_i.cause`, tval = `violation_pc_i` zero-extended to XLEN}.
- Pop condition: `exception_o.valid && ex_ack_i && !flush_i`.
- `exception_o.valid` equals `pending_o`, which is high when count != 0. `exception_o.cause` and `exception_o.tval` come combinationally from the head entry. When the queue is empty, cause and tval are 0.
- Full queue (count == DEPTH) without a pop in the same cycle: the push is dropped and `overflow_o` is set. With a pop in the same cycle, the push is accepted and count is unchanged.
- Push and pop on a non-full, non-empty queue in the same cycle: both happen and count is unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- `flush_i` sets pointers and count to 0 at the next edge. It has priority over any push or pop in the same cycle. It does not clear `overflow_o` or the counter.
- `overflow_o` clears only on reset.
- `ex_ack_i` while the queue is empty is ignored.

## Timing
- Reset values: `exception_o` all zero, `pending_o` 0, `overflow_o` 0, `viol_count_o` 0, `leds` 0.
- Push to visible output: 1 cycle. A pulse at edge N gives `exception_o.valid` high after edge N+1.
- Pop: the head advances at the acknowledging edge. The next entry, if any, is visible in the following cycle. Back-to-back acks drain one entry per cycle.
- `exception_o.valid` stays asserted with stable cause and tval until acknowledged or flushed.
- Reset mid-operation: all state clears immediately (asynchronous). Entries are lost.

## Configuration
- Macro: `CFI_VIOLATION_COUNTER_EN`.
- Defined:
  - `viol_count_o` increments by 1 on every cycle where `violation_i.valid && csr_en_i` is true. This includes dropped and flushed violations.
  - The counter saturates at 2^CNT_W−1. It is not cleared by flush.
  - `leds[3:0]` = `viol_count_o[3:0]`.
- Undefined:
  - No counter register is present.
  - `viol_count_o` is tied to 0 and `leds[3:0]` to 0.
- Queue behaviour is identical in both cases.

## Structure
- Shared package `cfi_pkg` holds:
  - `cfi_entry_t` (cause: `riscv::XLEN` bits, tval: `riscv::XLEN` bits).
  - `CFI_DEPTH_DEFAULT` = 4.
  - `CFI_CNT_W_DEFAULT` = 16.
- One sub-module, `cfi_viol_fifo`, contains storage, pointers, count, full and empty, with push/pop/flush ports. The top level holds the push/pop qualification, overflow flag, counter and LEDs.
- LED mapping, registered:
  - `leds[4]` = `overflow_o`.
  - `leds[5]` = `pending_o`.
  - `leds[6]` = `csr_en_i`.
  - `leds[7]` toggles on each accepted push.

## Test plan
- Single violation, no ack: pulse cause=3 (BREAKPOINT), pc=0x8000_0104 → after 1 cycle `exception_o` = {valid 1, cause 3, tval 0x80000104}, held for 10 cycles; ack → valid 0 on the next cycle.
- Burst: 4 pulses on consecutive cycles with pc 0x100, 0x104, 0x108, 0x10C; then ack each cycle → tvals appear in order, one per cycle, then `pending_o`=0. A 5th pulse before any ack → dropped, `overflow_o`=1, count=5 with the macro defined.
- Full plus simultaneous push/pop: fill to 4, then ack and pulse pc=0x200 in the same cycle → count stays 4; after draining, the last tval is 0x200.
- Flush: 2 entries queued, assert `flush_i` together with a pulse and an ack → next cycle `pending_o`=0, nothing stored; counter +1 with the macro defined.
- Enable gating: `csr_en_i`=0 with 3 pulses → no entries, counter unchanged at 0.
- Saturation and reset: with the macro defined and CNT_W=4, 20 pulses → `viol_count_o`=15. Assert `rst_ni` low mid-burst → all outputs 0 immediately, without waiting for a clock edge.
